ahb_lite_rif_bridge: RTL and testbench

- Second-generation AHB-Lite slave to register-interface (RIF) bridge, sitting between the AHB-Lite interconnect and a register file or peripheral CSR block.
- Adds over the previous adapter:
  - RIF wait states via a ready/error handshake.
  - Address-aligned byte strobes.
  - Alignment, size and security error checking.
  - Proper two-cycle ERROR response.
  - Optional access timeout.

---
 rtl/ahb_lite_rif_bridge.sv | 177 +++++++++++++++++
 tb/tb_ahb_lite_rif_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_rif_bridge.sv
// rtl/ahb_lite_rif_bridge.sv - AHB-Lite slave to register-interface bridge with wait states, strobes and error checks
//
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   HADDR/HSEL/HNONSEC/HSIZE/HTRANS/HWRITE/HREADYIN   AHB-Lite address phase
//   HWDATA                   AHB-Lite write data (data phase)
//   HRDATA/HRESP/HREADYOUT   AHB-Lite response
//   rif_addr/rif_wr_req/rif_rd_req/rif_wstrb/rif_wdata  register-interface request
//   rif_ready/rif_err/rif_rdata                          register-interface completion
//
// Optional build macro: BRIDGE_TIMEOUT_EN adds an access timeout of TIMEOUT_CYCLES wait cycles.

module ahb_lite_rif_bridge #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int SEC_TRANS      = 0,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int BYTE_COUNT     = DATA_WIDTH / 8
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic                    HSEL,
    input  logic                    HNONSEC,
    input  logic [2:0]              HSIZE,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic                    HREADYIN,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HRESP,
    output logic                    HREADYOUT,
    output logic [ADDR_WIDTH-1:0]   rif_addr,
    output logic                    rif_wr_req,
    output logic                    rif_rd_req,
    output logic [BYTE_COUNT-1:0]   rif_wstrb,
    output logic [DATA_WIDTH-1:0]   rif_wdata,
    input  logic                    rif_ready,
    input  logic                    rif_err,
    input  logic [DATA_WIDTH-1:0]   rif_rdata
);

    localparam int LANE_BITS = $clog2(BYTE_COUNT);

    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64 &&
        DATA_WIDTH != 128 && DATA_WIDTH != 256 && DATA_WIDTH != 512 && DATA_WIDTH != 1024) begin : g_bad_width
        $fatal(1, "ahb_lite_rif_bridge: illegal DATA_WIDTH %0d", DATA_WIDTH);
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $fatal(1, "ahb_lite_rif_bridge: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [2:0]              size_q, size_d;
    logic                    write_q, write_d;

    logic                    accept;
    logic                    illegal;
    logic                    can_accept;
    logic                    in_access;
    logic [ADDR_WIDTH-1:0]   align_mask;
    logic [31:0]             lane_off;
    logic [31:0]             lane_cnt;
    logic [BYTE_COUNT-1:0]   lane_mask;
    logic [DATA_WIDTH-1:0]   byte_mask;
    logic                    unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

`ifdef BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Address-phase qualification and legality of the transfer being offered.
    always_comb begin
        accept     = HSEL & HREADYIN & HTRANS[1];
        align_mask = ADDR_WIDTH'((32'd1 << HSIZE) - 32'd1);
        illegal    = (32'(HSIZE) > 32'(LANE_BITS)) ||
                     ((HADDR & align_mask) != '0) ||
                     ((SEC_TRANS != 0) && HNONSEC);
    end

    // Byte lanes covered by the latched transfer; legal transfers never wrap past the bus.
    always_comb begin
        lane_off  = 32'(addr_q) % 32'(BYTE_COUNT);
        lane_cnt  = 32'd1 << size_q;
        lane_mask = '0;
        for (int i = 0; i < BYTE_COUNT; i++) begin
            lane_mask[i] = (32'(i) >= lane_off) && (32'(i) < lane_off + lane_cnt);
        end
    end

    always_comb begin
        in_access  = (state_q == ACCESS);
        rif_wr_req = in_access & write_q;
        rif_rd_req = in_access & ~write_q;
        rif_addr   = addr_q;
        rif_wstrb  = in_access ? lane_mask : '0;
        for (int b = 0; b < BYTE_COUNT; b++) begin
            byte_mask[b*8 +: 8] = {8{rif_wstrb[b]}};
        end
        rif_wdata  = HWDATA & byte_mask;
        HRDATA     = (in_access && !write_q && rif_ready && !rif_err) ? (rif_rdata & byte_mask) : '0;
        HRESP      = (state_q == ERR1) || (state_q == ERR2);
        case (state_q)
            ACCESS:  HREADYOUT = rif_ready & ~rif_err;
            ERR1:    HREADYOUT = 1'b0;
            default: HREADYOUT = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        write_d    = write_q;
        can_accept = 1'b0;
        case (state_q)
            IDLE, ERR2: begin
                can_accept = 1'b1;
                state_d    = IDLE;
            end
            ACCESS: begin
                if (rif_ready) begin
                    if (rif_err) begin
                        state_d = ERR1;
                    end else begin
                        state_d    = IDLE;
                        can_accept = 1'b1;
                    end
                end
`ifdef BRIDGE_TIMEOUT_EN
                // This wait cycle is the TIMEOUT_CYCLES-th one: abort instead of waiting again.
                else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR1;
                end
`endif
            end
            ERR1:    state_d = ERR2;
            default: state_d = IDLE;
        endcase
        if (can_accept && accept) begin
            state_d = illegal ? ERR1 : ACCESS;
            addr_d  = HADDR;
            size_d  = HSIZE;
            write_d = HWRITE;
        end
`ifdef BRIDGE_TIMEOUT_EN
        tmo_cnt_d = (in_access && !rif_ready && state_d == ACCESS) ? tmo_cnt_q + TMO_W'(1) : '0;
`endif
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= '0;
            write_q   <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            write_q   <= write_d;
`ifdef BRIDGE_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ahb_lite_rif_bridge.sv
// tb/tb_ahb_lite_rif_bridge.sv - randomized self-checking bench for ahb_lite_rif_bridge
module tb_ahb_lite_rif_bridge;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int BC  = 4;
    localparam int TMO = 4;

    logic          HCLK;
    logic          HRESETn;
    logic [AW-1:0] HADDR;
    logic          HSEL;
    logic          HNONSEC;
    logic [2:0]    HSIZE;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [DW-1:0] HWDATA;
    logic          HREADYIN;
    logic [DW-1:0] HRDATA;
    logic          HRESP;
    logic          HREADYOUT;
    logic [AW-1:0] rif_addr;
    logic          rif_wr_req;
    logic          rif_rd_req;
    logic [BC-1:0] rif_wstrb;
    logic [DW-1:0] rif_wdata;
    logic          rif_ready;
    logic          rif_err;
    logic [DW-1:0] rif_rdata;

    ahb_lite_rif_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEC_TRANS(1), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HSEL(HSEL), .HNONSEC(HNONSEC),
        .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADYIN(HREADYIN),
        .HRDATA(HRDATA), .HRESP(HRESP), .HREADYOUT(HREADYOUT), .rif_addr(rif_addr),
        .rif_wr_req(rif_wr_req), .rif_rd_req(rif_rd_req), .rif_wstrb(rif_wstrb),
        .rif_wdata(rif_wdata), .rif_ready(rif_ready), .rif_err(rif_err), .rif_rdata(rif_rdata)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic [AW-1:0] addr;
        logic [2:0]    size;
        logic          write;
        logic [DW-1:0] wdata;
        logic          nonsec;
        logic          sel;
        logic [1:0]    htrans;
        int            waits;
        logic          err;
        logic [DW-1:0] rdata;
    } xfer_t;

    // One bus cycle: what the RIF side does and what the bridge must show.
    typedef struct {
        logic          rdy;
        logic          rerr;
        logic [DW-1:0] rdata;
        logic [DW-1:0] hwdata;
        logic          ex_ready;
        logic          ex_resp;
        logic          ex_wr;
        logic          ex_rd;
        logic [BC-1:0] ex_strb;
        logic [AW-1:0] ex_addr;
        logic [DW-1:0] ex_wdata;
        logic [DW-1:0] ex_hrdata;
    } cyc_t;

    xfer_t plan[$];
    cyc_t  dq[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic cyc_t quiet_cyc(input logic ready, input logic resp);
        cyc_t c;
        c.rdy       = 1'($urandom_range(0, 1));
        c.rerr      = 1'($urandom_range(0, 1));
        c.rdata     = $urandom;
        c.hwdata    = $urandom;
        c.ex_ready  = ready;
        c.ex_resp   = resp;
        c.ex_wr     = 1'b0;
        c.ex_rd     = 1'b0;
        c.ex_strb   = '0;
        c.ex_addr   = '0;
        c.ex_wdata  = '0;
        c.ex_hrdata = '0;
        return c;
    endfunction

    function automatic xfer_t mk(input int addr, input int size, input logic write, input logic [DW-1:0] wdata,
                                 input int waits, input logic err, input logic [DW-1:0] rdata, input logic nonsec);
        xfer_t x;
        x.addr = AW'(addr); x.size = 3'(size); x.write = write; x.wdata = wdata; x.nonsec = nonsec;
        x.sel = 1'b1; x.htrans = 2'b10; x.waits = waits; x.err = err; x.rdata = rdata;
        return x;
    endfunction

    // Turns an accepted transfer into the bus cycles of its data phase.
    function automatic void expand(input xfer_t x);
        int            nb;
        int            off;
        int            nw;
        logic          legal;
        logic          abort;
        logic [BC-1:0] strb;
        logic [DW-1:0] m;
        cyc_t          c;
        nb    = 1 << x.size;
        off   = int'(x.addr) % BC;
        legal = (x.size <= 2) && ((int'(x.addr) % nb) == 0) && !x.nonsec;
        if (!legal) begin
            dq.push_back(quiet_cyc(1'b0, 1'b1));
            dq.push_back(quiet_cyc(1'b1, 1'b1));
            return;
        end
        strb = BC'(((1 << nb) - 1) << off);
        for (int b = 0; b < BC; b++) m[b*8 +: 8] = strb[b] ? 8'hFF : 8'h00;
        nw    = x.waits;
        abort = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
        if (nw >= TMO) begin
            nw    = TMO;
            abort = 1'b1;
        end
`endif
        c = quiet_cyc(1'b0, 1'b0);
        c.hwdata   = x.wdata;
        c.ex_wr    = x.write;
        c.ex_rd    = !x.write;
        c.ex_strb  = strb;
        c.ex_addr  = x.addr;
        c.ex_wdata = x.wdata & m;
        c.rdy      = 1'b0;
        for (int i = 0; i < nw; i++) begin
            c.rerr  = 1'($urandom_range(0, 1));
            c.rdata = $urandom;
            dq.push_back(c);
        end
        if (!abort) begin
            c.rdy       = 1'b1;
            c.rerr      = x.err;
            c.rdata     = x.rdata;
            c.ex_ready  = !x.err;
            c.ex_hrdata = (!x.write && !x.err) ? (x.rdata & m) : '0;
            dq.push_back(c);
        end
        if (abort || x.err) begin
            dq.push_back(quiet_cyc(1'b0, 1'b1));
            dq.push_back(quiet_cyc(1'b1, 1'b1));
        end
    endfunction

    task automatic run_plan();
        xfer_t ap;
        cyc_t  c;
        logic  have_ap = 1'b0;
        int    budget  = 0;
        while ((plan.size() > 0 || dq.size() > 0 || have_ap) && budget < 40000) begin
            budget++;
            @(negedge HCLK);
            c = (dq.size() > 0) ? dq.pop_front() : quiet_cyc(1'b1, 1'b0);
            if (!have_ap && plan.size() > 0) begin
                ap      = plan.pop_front();
                have_ap = 1'b1;
            end
            HSEL      = have_ap ? ap.sel : 1'b0;
            HTRANS    = have_ap ? ap.htrans : 2'b00;
            HADDR     = have_ap ? ap.addr : AW'($urandom);
            HSIZE     = have_ap ? ap.size : 3'($urandom);
            HWRITE    = have_ap ? ap.write : 1'($urandom);
            HNONSEC   = have_ap ? ap.nonsec : 1'($urandom);
            HREADYIN  = c.ex_ready;
            HWDATA    = c.hwdata;
            rif_ready = c.rdy;
            rif_err   = c.rerr;
            rif_rdata = c.rdata;
            #1;
            check("hreadyout", 32'(HREADYOUT), 32'(c.ex_ready));
            check("hresp",     32'(HRESP),     32'(c.ex_resp));
            check("wr_req",    32'(rif_wr_req), 32'(c.ex_wr));
            check("rd_req",    32'(rif_rd_req), 32'(c.ex_rd));
            check("wstrb",     32'(rif_wstrb), 32'(c.ex_strb));
            check("wdata",     rif_wdata,      c.ex_wdata);
            check("hrdata",    HRDATA,         c.ex_hrdata);
            if (c.ex_wr || c.ex_rd) check("rif_addr", 32'(rif_addr), 32'(c.ex_addr));
            if (c.ex_ready && have_ap) begin
                if (ap.sel && ap.htrans[1]) expand(ap);
                have_ap = 1'b0;
            end
        end
        check("cycle_budget", 32'(budget < 40000), 32'd1);
    endtask

    task automatic add_random(input int n);
        xfer_t x;
        int    nb;
        for (int i = 0; i < n; i++) begin
            x.size   = 3'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
            nb       = 1 << x.size;
            x.addr   = AW'($urandom);
            if ($urandom_range(0, 4) != 0) x.addr = AW'((int'(x.addr) / nb) * nb);
            x.write  = 1'($urandom_range(0, 1));
            x.wdata  = $urandom;
            x.nonsec = ($urandom_range(0, 9) == 0);
            x.sel    = ($urandom_range(0, 9) != 0);
            x.htrans = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            x.waits  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 6);
            x.err    = ($urandom_range(0, 9) == 0);
            x.rdata  = $urandom;
            plan.push_back(x);
        end
    endtask

    initial begin
        HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HADDR = '0; HSIZE = '0; HWRITE = 1'b0;
        HNONSEC = 1'b0; HWDATA = 32'hFFFF_FFFF; HREADYIN = 1'b1;
        rif_ready = 1'b1; rif_err = 1'b0; rif_rdata = 32'hFFFF_FFFF;
        #12;
        check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("rst_hresp",     32'(HRESP),     32'd0);
        check("rst_hrdata",    HRDATA,         32'd0);
        check("rst_wr_req",    32'(rif_wr_req), 32'd0);
        check("rst_rd_req",    32'(rif_rd_req), 32'd0);
        check("rst_addr",      32'(rif_addr),  32'd0);
        check("rst_wstrb",     32'(rif_wstrb), 32'd0);
        check("rst_wdata",     rif_wdata,      32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        plan.push_back(mk(12'h006, 1, 1'b1, 32'hABCD_0000, 0, 1'b0, 32'h0, 1'b0));
        plan.push_back(mk(12'h010, 2, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0));
        plan.push_back(mk(12'h003, 2, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0));
        plan.push_back(mk(12'h008, 2, 1'b1, 32'h5555_AAAA, 0, 1'b1, 32'h0, 1'b0));
        plan.push_back(mk(12'h00C, 2, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b1));
        plan.push_back(mk(12'h000, 2, 1'b1, 32'h1111_1111, 0, 1'b0, 32'h0, 1'b0));
        plan.push_back(mk(12'h004, 2, 1'b1, 32'h2222_2222, 0, 1'b0, 32'h0, 1'b0));
        plan.push_back(mk(12'h008, 2, 1'b1, 32'h3333_3333, 0, 1'b0, 32'h0, 1'b0));
        plan.push_back(mk(12'h000, 1, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 1'b0));
        plan.push_back(mk(12'h002, 0, 1'b1, 32'h00EE_0000, 0, 1'b0, 32'h0, 1'b0));
        plan.push_back(mk(12'h020, 3, 1'b0, 32'h0, 0, 1'b0, 32'h0, 1'b0));
`ifdef BRIDGE_TIMEOUT_EN
        plan.push_back(mk(12'h030, 2, 1'b0, 32'h0, 10, 1'b0, 32'h0, 1'b0));
        plan.push_back(mk(12'h034, 2, 1'b0, 32'h0, TMO - 1, 1'b0, 32'h8765_4321, 1'b0));
`endif
        add_random(300);
        run_plan();

        // Reset pulse while a read is waiting on the RIF.
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 12'h040; HSIZE = 3'd2; HWRITE = 1'b0; HNONSEC = 1'b0;
        HREADYIN = 1'b1; rif_ready = 1'b0; rif_err = 1'b0;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HREADYIN = 1'b0;
        #1;
        check("mid_rd_req", 32'(rif_rd_req), 32'd1);
        check("mid_hreadyout", 32'(HREADYOUT), 32'd0);
        rif_ready = 1'b1; rif_rdata = 32'hDEAD_BEEF;
        #1;
        check("mid_hrdata", HRDATA, 32'hDEAD_BEEF);
        HRESETn = 1'b0;
        #1;
        check("arst_rd_req",    32'(rif_rd_req), 32'd0);
        check("arst_hreadyout", 32'(HREADYOUT), 32'd1);
        check("arst_hresp",     32'(HRESP),     32'd0);
        check("arst_hrdata",    HRDATA,         32'd0);
        check("arst_wstrb",     32'(rif_wstrb), 32'd0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        plan.push_back(mk(12'h044, 2, 1'b0, 32'h0, 1, 1'b0, 32'h0BAD_CAFE, 1'b0));
        add_random(100);
        run_plan();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
